// File: rtl/step_seq_pkg.sv
// Shared types and constants for the step-sequencer grid.
// Holds the controller state encoding and the one-hot direction codes from the cursor decoder.
package step_seq_pkg;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

endpackage

// File: rtl/step_timer.sv
// Playback tick counter: counts 0..TICKS_PER_STEP-1 while run is high.
// advance is combinational from the registered count and is high on the last tick of a step.
module step_timer #(
  parameter int TICKS_PER_STEP = 12_500_000
) (
  input  logic Clock,
  input  logic nReset,
  input  logic restart,
  input  logic run,
  output logic advance
);

  localparam int TICK_W = $clog2(TICKS_PER_STEP);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);

  logic [TICK_W-1:0] r_tick;
  logic              w_at_last;

  assign w_at_last = (r_tick == TICK_LAST);
  assign advance   = run && w_at_last;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_tick <= '0;
    end else if (restart) begin
      r_tick <= '0;
    end else if (run) begin
      r_tick <= w_at_last ? '0 : r_tick + TICK_W'(1);
    end
  end

endmodule

// File: rtl/step_grid_controller.sv
// Step-sequencer grid controller: cursor, ROWS x COLS pattern, playback head and row triggers.
// Edits/moves land 1 cycle after the pulse; triggers are registered 1-cycle pulses per step.
module step_grid_controller
  import step_seq_pkg::*;
#(
  parameter  int COLS           = 16,
  parameter  int ROWS           = 4,
  parameter  int TICKS_PER_STEP = 12_500_000,
  localparam int COL_W          = $clog2(COLS),
  localparam int ROW_W          = $clog2(ROWS)
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic [3:0]           Direction,
  input  logic                 Command,
  input  logic                 Start,
  input  logic                 Clear,
  output logic                 input_en,
  output logic [COL_W-1:0]     cursor_col,
  output logic [ROW_W-1:0]     cursor_row,
  output logic [ROWS*COLS-1:0] pattern,
  output logic [COL_W-1:0]     play_col,
  output logic                 step_pulse,
  output logic [ROWS-1:0]      row_trigger,
  output logic                 running
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_t                 r_state;
  logic [COL_W-1:0]       r_cur_col;
  logic [ROW_W-1:0]       r_cur_row;
  logic [ROWS*COLS-1:0]   r_pattern;
  logic [COL_W-1:0]       r_play_col;
  logic                   r_step_pulse;
  logic [ROWS-1:0]        r_row_trigger;
  logic [ROW_W-1:0]       r_clr_row;

  state_t                 w_state_nxt;
  logic [COL_W-1:0]       w_cur_col_nxt;
  logic [ROW_W-1:0]       w_cur_row_nxt;
  logic [ROWS*COLS-1:0]   w_pattern_nxt;
  logic [COL_W-1:0]       w_play_col_nxt;
  logic                   w_step_pulse_nxt;
  logic [ROWS-1:0]        w_row_trigger_nxt;
  logic [ROW_W-1:0]       w_clr_row_nxt;
  logic [COL_W-1:0]       w_play_col_inc;
  logic                   w_restart;
  logic                   w_advance;

  // Triggers always sample the registered pattern, i.e. before any edit in the same cycle.
  function automatic logic [ROWS-1:0] col_bits(input logic [ROWS*COLS-1:0] pat,
                                               input logic [COL_W-1:0]     col);
    logic [ROWS-1:0] bits;
    bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (COL_W'(c) == col) bits[r] = pat[r*COLS + c];
      end
    end
    return bits;
  endfunction

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_timer (
    .Clock  (Clock),
    .nReset (nReset),
    .restart(w_restart),
    .run    (r_state == RUN),
    .advance(w_advance)
  );

  assign w_play_col_inc = (r_play_col == COL_LAST) ? '0 : r_play_col + COL_W'(1);

  always_comb begin
    w_state_nxt       = r_state;
    w_cur_col_nxt     = r_cur_col;
    w_cur_row_nxt     = r_cur_row;
    w_pattern_nxt     = r_pattern;
    w_play_col_nxt    = r_play_col;
    w_step_pulse_nxt  = 1'b0;
    w_row_trigger_nxt = '0;
    w_clr_row_nxt     = r_clr_row;
    w_restart         = 1'b0;

    case (r_state)
      EDIT, RUN: begin
        if (Clear) begin
          w_state_nxt   = CLEAR;
          w_clr_row_nxt = '0;
          w_restart     = 1'b1;
        end else begin
          if (Command) begin
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                if (ROW_W'(r) == r_cur_row && COL_W'(c) == r_cur_col)
                  w_pattern_nxt[r*COLS + c] = ~r_pattern[r*COLS + c];
              end
            end
          end

          case (Direction)
            DIR_UP:    w_cur_row_nxt = (r_cur_row == '0) ? ROW_LAST : r_cur_row - ROW_W'(1);
            DIR_DOWN:  w_cur_row_nxt = (r_cur_row == ROW_LAST) ? '0 : r_cur_row + ROW_W'(1);
            DIR_LEFT:  w_cur_col_nxt = (r_cur_col == '0) ? COL_LAST : r_cur_col - COL_W'(1);
            DIR_RIGHT: w_cur_col_nxt = (r_cur_col == COL_LAST) ? '0 : r_cur_col + COL_W'(1);
            default:   ;
          endcase

          if (Start) begin
            w_restart = 1'b1;
            if (r_state == EDIT) begin
              w_state_nxt       = RUN;
              w_play_col_nxt    = '0;
              w_step_pulse_nxt  = 1'b1;
              w_row_trigger_nxt = col_bits(r_pattern, '0);
            end else begin
              w_state_nxt = EDIT;
            end
          end else if (r_state == RUN && w_advance) begin
            w_play_col_nxt    = w_play_col_inc;
            w_step_pulse_nxt  = 1'b1;
            w_row_trigger_nxt = col_bits(r_pattern, w_play_col_inc);
          end
        end
      end

      CLEAR: begin
        w_restart = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
          if (ROW_W'(r) == r_clr_row) w_pattern_nxt[r*COLS +: COLS] = '0;
        end
        if (r_clr_row == ROW_LAST) begin
          w_state_nxt    = EDIT;
          w_cur_col_nxt  = '0;
          w_cur_row_nxt  = '0;
          w_play_col_nxt = '0;
          w_clr_row_nxt  = '0;
        end else begin
          w_clr_row_nxt = r_clr_row + ROW_W'(1);
        end
      end

      default: begin
        w_state_nxt = EDIT;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state       <= EDIT;
      r_cur_col     <= '0;
      r_cur_row     <= '0;
      r_pattern     <= '0;
      r_play_col    <= '0;
      r_step_pulse  <= 1'b0;
      r_row_trigger <= '0;
      r_clr_row     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur_col     <= w_cur_col_nxt;
      r_cur_row     <= w_cur_row_nxt;
      r_pattern     <= w_pattern_nxt;
      r_play_col    <= w_play_col_nxt;
      r_step_pulse  <= w_step_pulse_nxt;
      r_row_trigger <= w_row_trigger_nxt;
      r_clr_row     <= w_clr_row_nxt;
    end
  end

  assign input_en    = (r_state != CLEAR);
  assign running     = (r_state == RUN);
  assign cursor_col  = r_cur_col;
  assign cursor_row  = r_cur_row;
  assign pattern     = r_pattern;
  assign play_col    = r_play_col;
  assign step_pulse  = r_step_pulse;
  assign row_trigger = r_row_trigger;

endmodule

// File: tb/tb_step_grid_controller.sv
// Directed bench for step_grid_controller with COLS=16, ROWS=4, TICKS_PER_STEP=4.
module tb_step_grid_controller;

  logic        Clock;
  logic        nReset;
  logic [3:0]  Direction;
  logic        Command;
  logic        Start;
  logic        Clear;
  logic        input_en;
  logic [3:0]  cursor_col;
  logic [1:0]  cursor_row;
  logic [63:0] pattern;
  logic [3:0]  play_col;
  logic        step_pulse;
  logic [3:0]  row_trigger;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] PAT3 = 64'h8000_0002_0000_0001;

  step_grid_controller #(
    .COLS(16),
    .ROWS(4),
    .TICKS_PER_STEP(4)
  ) dut (
    .Clock      (Clock),
    .nReset     (nReset),
    .Direction  (Direction),
    .Command    (Command),
    .Start      (Start),
    .Clear      (Clear),
    .input_en   (input_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .pattern    (pattern),
    .play_col   (play_col),
    .step_pulse (step_pulse),
    .row_trigger(row_trigger),
    .running    (running)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic pulse(input logic [3:0] dir, input logic cmd, input logic st, input logic clr);
    @(negedge Clock);
    Direction = dir; Command = cmd; Start = st; Clear = clr;
    @(negedge Clock);
    Direction = 4'b0; Command = 1'b0; Start = 1'b0; Clear = 1'b0;
  endtask

  task automatic test_reset();
    nReset = 1'b0; Direction = 4'b0; Command = 1'b0; Start = 1'b0; Clear = 1'b0;
    repeat (2) @(negedge Clock);
    n_checks++;
    if ({input_en, running, step_pulse, row_trigger, play_col, cursor_row, cursor_col, pattern} !== {1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'b0, 4'b0, 64'b0}) begin
      n_fail++;
      $display("FAIL reset_values: en=%b run=%b sp=%b trig=%b pc=%0d row=%0d col=%0d pat=%h",
               input_en, running, step_pulse, row_trigger, play_col, cursor_row, cursor_col, pattern);
    end
    nReset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_move_wrap();
    pulse(4'b0100, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({cursor_row, cursor_col} !== {2'd0, 4'd15}) begin
      n_fail++; $display("FAIL wrap_left: got (%0d,%0d) want (0,15)", cursor_row, cursor_col);
    end
    pulse(4'b0001, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({cursor_row, cursor_col} !== {2'd3, 4'd15}) begin
      n_fail++; $display("FAIL wrap_up: got (%0d,%0d) want (3,15)", cursor_row, cursor_col);
    end
    pulse(4'b1000, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cursor_col !== 4'd0) begin
      n_fail++; $display("FAIL wrap_right: got col %0d want 0", cursor_col);
    end
    pulse(4'b0010, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cursor_row !== 2'd0) begin
      n_fail++; $display("FAIL wrap_down: got row %0d want 0", cursor_row);
    end
  endtask

  task automatic test_invalid_dir();
    pulse(4'b1000, 1'b0, 1'b0, 1'b0);
    pulse(4'b0011, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({cursor_row, cursor_col} !== {2'd0, 4'd1}) begin
      n_fail++; $display("FAIL dir_0011: got (%0d,%0d) want (0,1)", cursor_row, cursor_col);
    end
    pulse(4'b0000, 1'b0, 1'b0, 1'b0);
    pulse(4'b1100, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({cursor_row, cursor_col} !== {2'd0, 4'd1}) begin
      n_fail++; $display("FAIL dir_multi: got (%0d,%0d) want (0,1)", cursor_row, cursor_col);
    end
    pulse(4'b0100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_toggle();
    pulse(4'b1000, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (pattern !== 64'h1 || cursor_col !== 4'd1) begin
      n_fail++; $display("FAIL toggle_move: pat=%h col=%0d want pat=1 col=1", pattern, cursor_col);
    end
    pulse(4'b0100, 1'b0, 1'b0, 1'b0);
    pulse(4'b0000, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (pattern !== 64'h0 || cursor_col !== 4'd0) begin
      n_fail++; $display("FAIL toggle_back: pat=%h col=%0d want pat=0 col=0", pattern, cursor_col);
    end
  endtask

  task automatic test_run();
    logic [3:0] exp_trig;
    logic [3:0] exp_col;
    pulse(4'b1000, 1'b1, 1'b0, 1'b0);   // set (0,0), go to (0,1)
    pulse(4'b0010, 1'b0, 1'b0, 1'b0);
    pulse(4'b0010, 1'b0, 1'b0, 1'b0);
    pulse(4'b0010, 1'b1, 1'b0, 1'b0);   // set (2,1), go to (3,1)
    pulse(4'b0100, 1'b0, 1'b0, 1'b0);
    pulse(4'b0100, 1'b0, 1'b0, 1'b0);
    pulse(4'b0000, 1'b1, 1'b0, 1'b0);   // set (3,15)
    n_checks++;
    if (pattern !== PAT3 || {cursor_row, cursor_col} !== {2'd3, 4'd15}) begin
      n_fail++; $display("FAIL setup_cells: pat=%h cur=(%0d,%0d) want pat=%h cur=(3,15)",
                         pattern, cursor_row, cursor_col, PAT3);
    end
    pulse(4'b0000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({running, step_pulse, play_col, row_trigger} !== {1'b1, 1'b1, 4'd0, 4'b0001}) begin
      n_fail++; $display("FAIL first_step: run=%b sp=%b pc=%0d trig=%b want 1 1 0 0001",
                         running, step_pulse, play_col, row_trigger);
    end
    for (int k = 1; k <= 64; k++) begin
      @(negedge Clock);
      exp_col = 4'((k / 4) % 16);
      case (exp_col)
        4'd0:    exp_trig = 4'b0001;
        4'd1:    exp_trig = 4'b0100;
        4'd15:   exp_trig = 4'b1000;
        default: exp_trig = 4'b0000;
      endcase
      n_checks++;
      if ((k % 4) == 0) begin
        if ({step_pulse, play_col, row_trigger} !== {1'b1, exp_col, exp_trig}) begin
          n_fail++; $display("FAIL step_k%0d: sp=%b pc=%0d trig=%b want 1 %0d %b",
                             k, step_pulse, play_col, row_trigger, exp_col, exp_trig);
        end
      end else begin
        if (step_pulse !== 1'b0 || row_trigger !== 4'b0) begin
          n_fail++; $display("FAIL idle_k%0d: sp=%b trig=%b want 0 0000", k, step_pulse, row_trigger);
        end
      end
    end
  endtask

  task automatic test_stop();
    repeat (3) @(negedge Clock);
    pulse(4'b0000, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({running, step_pulse, play_col} !== {1'b0, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL stop: run=%b sp=%b pc=%0d want 0 0 1", running, step_pulse, play_col);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      n_checks++;
      if (step_pulse !== 1'b0 || play_col !== 4'd1 || row_trigger !== 4'b0) begin
        n_fail++; $display("FAIL stopped_k%0d: sp=%b pc=%0d trig=%b want 0 1 0000",
                           k, step_pulse, play_col, row_trigger);
      end
    end
  endtask

  task automatic test_clear();
    pulse(4'b0000, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge Clock);
    n_checks++;
    if (play_col !== 4'd1 || running !== 1'b1) begin
      n_fail++; $display("FAIL pre_clear: pc=%0d run=%b want 1 1", play_col, running);
    end
    @(negedge Clock);
    Clear = 1'b1; Command = 1'b1; Start = 1'b1;
    @(negedge Clock);
    Clear = 1'b0; Command = 1'b0; Start = 1'b0; Direction = 4'b0100;
    n_checks++;
    if ({input_en, running, step_pulse} !== 3'b000 || pattern !== PAT3) begin
      n_fail++; $display("FAIL clear_entry: en=%b run=%b sp=%b pat=%h want 0 0 0 %h",
                         input_en, running, step_pulse, pattern, PAT3);
    end
    @(negedge Clock);
    Direction = 4'b0001;
    n_checks++;
    if (input_en !== 1'b0 || pattern !== 64'h8000_0002_0000_0000) begin
      n_fail++; $display("FAIL clear_row0: en=%b pat=%h want 0 8000000200000000", input_en, pattern);
    end
    @(negedge Clock);
    Direction = 4'b1000;
    n_checks++;
    if (input_en !== 1'b0) begin
      n_fail++; $display("FAIL clear_c3: en=%b want 0", input_en);
    end
    @(negedge Clock);
    Direction = 4'b0010;
    n_checks++;
    if (input_en !== 1'b0 || pattern !== 64'h8000_0000_0000_0000) begin
      n_fail++; $display("FAIL clear_row2: en=%b pat=%h want 0 8000000000000000", input_en, pattern);
    end
    @(negedge Clock);
    Direction = 4'b0000;
    n_checks++;
    if ({input_en, running, play_col, cursor_row, cursor_col} !== {1'b1, 1'b0, 4'd0, 2'd0, 4'd0}
        || pattern !== 64'h0) begin
      n_fail++; $display("FAIL clear_done: en=%b run=%b pc=%0d cur=(%0d,%0d) pat=%h want 1 0 0 (0,0) 0",
                         input_en, running, play_col, cursor_row, cursor_col, pattern);
    end
    @(negedge Clock);
    n_checks++;
    if ({cursor_row, cursor_col} !== {2'd0, 4'd0} || input_en !== 1'b1) begin
      n_fail++; $display("FAIL post_clear: cur=(%0d,%0d) en=%b want (0,0) 1", cursor_row, cursor_col, input_en);
    end
  endtask

  task automatic test_reset_mid_clear();
    pulse(4'b1000, 1'b1, 1'b0, 1'b0);
    pulse(4'b0000, 1'b0, 1'b1, 1'b0);
    pulse(4'b0000, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (input_en !== 1'b0 || pattern !== 64'h1 || cursor_col !== 4'd1) begin
      n_fail++; $display("FAIL mid_clear_pre: en=%b pat=%h col=%0d want 0 1 1", input_en, pattern, cursor_col);
    end
    #2 nReset = 1'b0;
    #1;
    n_checks++;
    if ({input_en, running, step_pulse, row_trigger, play_col, cursor_row, cursor_col, pattern} !== {1'b1, 1'b0, 1'b0, 4'b0, 4'b0, 2'b0, 4'b0, 64'b0}) begin
      n_fail++;
      $display("FAIL async_reset: en=%b run=%b sp=%b trig=%b pc=%0d row=%0d col=%0d pat=%h",
               input_en, running, step_pulse, row_trigger, play_col, cursor_row, cursor_col, pattern);
    end
    @(negedge Clock);
    nReset = 1'b1;
    repeat (2) @(negedge Clock);
    n_checks++;
    if (input_en !== 1'b1 || running !== 1'b0 || pattern !== 64'h0) begin
      n_fail++; $display("FAIL no_resume: en=%b run=%b pat=%h want 1 0 0", input_en, running, pattern);
    end
  endtask

  initial begin
    test_reset();
    test_move_wrap();
    test_invalid_dir();
    test_toggle();
    test_run();
    test_stop();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
